// File: rtl/program_loader.sv
// rtl/program_loader.sv - packs a boot byte stream into 32-bit words and writes program memory.
// Optional LOADER_CHECKSUM_EN adds an 8-bit running sum output of accepted bytes.
`ifndef X_LENGTH
`define X_LENGTH 32
`endif

module program_loader #(
  parameter int ADDR_WIDTH = 5,
  parameter int DATA_WIDTH = `X_LENGTH,
  parameter int WORDS      = 32
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [7:0]            in_data_i,
  input  logic                  in_last_i,
  output logic                  mem_wren_o,
  output logic [ADDR_WIDTH-1:0] mem_address_o,
  output logic [DATA_WIDTH-1:0] mem_data_o,
  output logic                  cpu_hold_o,
  output logic                  done_o,
`ifdef LOADER_CHECKSUM_EN
  output logic [7:0]            checksum_o,
`endif
  output logic [ADDR_WIDTH:0]   word_count_o
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_WRITE, S_DONE} state_t;

  localparam logic [ADDR_WIDTH:0] LAST_WORD = (ADDR_WIDTH+1)'(WORDS - 1);

  state_t                  state_q;
  logic                    in_ready_q;
  logic                    mem_wren_q;
  logic                    cpu_hold_q;
  logic                    done_q;
  logic                    last_q;
  logic [1:0]              byte_idx_q;
  logic [ADDR_WIDTH-1:0]   mem_address_q;
  logic [DATA_WIDTH-1:0]   data_q;
  logic [ADDR_WIDTH:0]     word_count_q;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]              checksum_q;
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= S_IDLE;
      in_ready_q    <= 1'b0;
      mem_wren_q    <= 1'b0;
      cpu_hold_q    <= 1'b0;
      done_q        <= 1'b0;
      last_q        <= 1'b0;
      byte_idx_q    <= '0;
      mem_address_q <= '0;
      data_q        <= '0;
      word_count_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
      checksum_q    <= '0;
`endif
    end else begin
      case (state_q)
        S_IDLE, S_DONE: begin
          if (start_i) begin
            state_q       <= S_LOAD;
            in_ready_q    <= 1'b1;
            cpu_hold_q    <= 1'b1;
            done_q        <= 1'b0;
            last_q        <= 1'b0;
            byte_idx_q    <= '0;
            mem_address_q <= '0;
            data_q        <= '0;
            word_count_q  <= '0;
`ifdef LOADER_CHECKSUM_EN
            checksum_q    <= '0;
`endif
          end
        end
        S_LOAD: begin
          // in_ready is always 1 here, so in_valid alone marks a transfer
          if (in_valid_i) begin
            data_q[{byte_idx_q, 3'b000} +: 8] <= in_data_i;
            byte_idx_q <= byte_idx_q + 2'd1;
`ifdef LOADER_CHECKSUM_EN
            checksum_q <= checksum_q + in_data_i;
`endif
            if (byte_idx_q == 2'd3 || in_last_i) begin
              state_q    <= S_WRITE;
              in_ready_q <= 1'b0;
              mem_wren_q <= 1'b1;
              last_q     <= in_last_i;
            end
          end
        end
        S_WRITE: begin
          mem_wren_q   <= 1'b0;
          word_count_q <= word_count_q + 1'b1;
          data_q       <= '0;
          byte_idx_q   <= '0;
          // Address is held on the final word so a full image never wraps to word 0
          if (last_q || word_count_q == LAST_WORD) begin
            state_q    <= S_DONE;
            cpu_hold_q <= 1'b0;
            done_q     <= 1'b1;
          end else begin
            state_q       <= S_LOAD;
            in_ready_q    <= 1'b1;
            mem_address_q <= mem_address_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o    = in_ready_q;
  assign mem_wren_o    = mem_wren_q;
  assign mem_address_o = mem_address_q;
  assign mem_data_o    = data_q;
  assign cpu_hold_o    = cpu_hold_q;
  assign done_o        = done_q;
  assign word_count_o  = word_count_q;
`ifdef LOADER_CHECKSUM_EN
  assign checksum_o    = checksum_q;
`endif

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - scoreboard bench for program_loader; covers LOADER_CHECKSUM_EN when defined.
module tb_program_loader;

  logic        clk_i = 1'b0;
  logic        rst_ni = 1'b0;
  logic        start_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [7:0]  in_data_i = 8'h00;
  logic        in_last_i = 1'b0;
  logic        mem_wren_o;
  logic [4:0]  mem_address_o;
  logic [31:0] mem_data_o;
  logic        cpu_hold_o;
  logic        done_o;
  logic [5:0]  word_count_o;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]  checksum_o;
`endif

  program_loader dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .start_i(start_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .in_data_i(in_data_i), .in_last_i(in_last_i),
    .mem_wren_o(mem_wren_o), .mem_address_o(mem_address_o), .mem_data_o(mem_data_o),
    .cpu_hold_o(cpu_hold_o), .done_o(done_o),
`ifdef LOADER_CHECKSUM_EN
    .checksum_o(checksum_o),
`endif
    .word_count_o(word_count_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  logic [36:0] sb_q[$];
  logic [7:0]  img[0:139];
  bit          chk_gap = 1'b0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Every write the DUT makes must match the head of the scoreboard.
  always @(negedge clk_i) begin
    if (rst_ni && mem_wren_o) begin
      if (sb_q.size() == 0) begin
        check("unexpected_write", {27'd0, mem_address_o, mem_data_o}, 64'hFFFF_FFFF_FFFF_FFFF);
      end else begin
        logic [36:0] e;
        e = sb_q.pop_front();
        check("wr_addr", mem_address_o, e[36:32]);
        check("wr_data", mem_data_o, e[31:0]);
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk_i); start_i = 1'b1;
    @(posedge clk_i); #1 start_i = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic last, input int gap);
    int n;
    repeat (gap) begin
      @(negedge clk_i);
      if (chk_gap) check("gap_ready", in_ready_o, 1);
    end
    @(negedge clk_i);
    in_valid_i = 1'b1; in_data_i = b; in_last_i = last;
    n = 0;
    while (!in_ready_o && n < 40) begin @(negedge clk_i); n++; end
    if (n >= 40) check("byte_timeout", 0, 1);
    @(posedge clk_i); #1;
    in_valid_i = 1'b0; in_last_i = 1'b0;
  endtask

  // Pushes the words the loader should write for img[0..n-1], capped at 32 words.
  task automatic push_expected(input int n);
    int w;
    logic [31:0] d;
    w = (n + 3) / 4;
    if (w > 32) w = 32;
    for (int j = 0; j < w; j++) begin
      d = '0;
      for (int k = 0; k < 4; k++)
        if (4*j + k < n) d[8*k +: 8] = img[4*j + k];
      sb_q.push_back({j[4:0], d});
    end
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done_o && n < 60) begin @(negedge clk_i); n++; end
    if (n >= 60) check("done_timeout", 0, 1);
  endtask

  task automatic load_image(input int n, input int gap, input string tag);
    pulse_start();
    push_expected(n);
    for (int i = 0; i < n; i++) send_byte(img[i], i == n - 1, gap);
    wait_done();
    check({tag, "_done"}, done_o, 1);
    check({tag, "_hold"}, cpu_hold_o, 0);
    check({tag, "_count"}, word_count_o, 6'((n + 3) / 4));
    check({tag, "_sb_empty"}, sb_q.size(), 0);
  endtask

  initial begin
    repeat (3) @(posedge clk_i);
    #1;
    check("rst_outputs", {in_ready_o, mem_wren_o, cpu_hold_o, done_o, word_count_o, mem_address_o, mem_data_o}, 64'd0);
    rst_ni = 1'b1;

    // T1: reset two bytes into a load; nothing may be written
    pulse_start();
    check("t1_hold", cpu_hold_o, 1);
    send_byte(8'h11, 1'b0, 0);
    send_byte(8'h22, 1'b0, 0);
    #2 rst_ni = 1'b0;
    @(posedge clk_i); #1;
    check("t1_reset_outputs", {in_ready_o, mem_wren_o, cpu_hold_o, done_o, word_count_o, mem_address_o, mem_data_o}, 64'd0);
    @(negedge clk_i); rst_ni = 1'b1;
    repeat (10) @(negedge clk_i);
    check("t1_idle_ready", in_ready_o, 0);

    // T2: single instruction word
    img[0] = 8'h13; img[1] = 8'h00; img[2] = 8'h50; img[3] = 8'h00;
    load_image(4, 0, "t2");

    // T3: two words, restart from DONE
    for (int i = 0; i < 8; i++) img[i] = 8'(i + 1);
    load_image(8, 0, "t3");

    // T4: partial word, back-to-back then with valid gaps
    img[0] = 8'hAA; img[1] = 8'hBB;
    load_image(2, 0, "t4a");
    chk_gap = 1'b1;
    load_image(2, 3, "t4b");
    chk_gap = 1'b0;

    // T5: overflow without in_last; mid-load start must be ignored
    for (int i = 0; i < 132; i++) img[i] = 8'($urandom_range(0, 255));
    pulse_start();
    push_expected(132);
    for (int i = 0; i < 128; i++) begin
      if (i == 50) begin
        pulse_start();
        check("t5_hold_mid", cpu_hold_o, 1);
      end
      send_byte(img[i], 1'b0, 0);
    end
    wait_done();
    check("t5_done", done_o, 1);
    check("t5_count", word_count_o, 6'd32);
    check("t5_sb_empty", sb_q.size(), 0);
    @(negedge clk_i);
    in_valid_i = 1'b1; in_data_i = img[128];
    repeat (5) @(negedge clk_i);
    check("t5_no_accept", in_ready_o, 0);
    in_valid_i = 1'b0;
    check("t5_count_hold", word_count_o, 6'd32);

`ifdef LOADER_CHECKSUM_EN
    // T6: checksum excludes pad bytes and clears on restart
    img[0] = 8'hFF; img[1] = 8'h02; img[2] = 8'h03; img[3] = 8'h04;
    load_image(4, 0, "t6");
    check("t6_checksum", checksum_o, 8'h08);
    pulse_start();
    check("t6_cleared", checksum_o, 8'h00);
    img[0] = 8'h10;
    push_expected(1);
    send_byte(8'h10, 1'b1, 0);
    wait_done();
    check("t6_partial_checksum", checksum_o, 8'h10);
`endif

    repeat (5) @(negedge clk_i);
    check("final_sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
